muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer and HI/LO register owner for the MIPS core. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from decode. It runs a 32-step radix-2 shift-add or restoring-divide datapath and writes HI/LO on completion. It raises a pipeline stall whenever the CPU touches HI/LO or issues a new mult/div while one is in flight.

---
 rtl/muldiv_pkg.sv | 47 ++++
 rtl/muldiv_step.sv | 31 +++
 rtl/muldiv_ctrl.sv | 154 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multiply/divide sequencer.
// Optional single-cycle multiply is enabled by defining MULDIV_FAST_MULT_EN.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  typedef enum logic {
    CLS_MUL = 1'b0,
    CLS_DIV = 1'b1
  } muldiv_cls_t;

  localparam int ITER_LAST = 31;

  function automatic logic is_muldiv(input muldiv_op_t op);
    return (op == MULT) || (op == MULTU) ||
           (op == DIV)  || (op == DIVU);
  endfunction

  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

  function automatic muldiv_cls_t cls_of(input muldiv_op_t op);
    return ((op == DIV) || (op == DIVU)) ? CLS_DIV : CLS_MUL;
  endfunction

  function automatic logic [31:0] mag(
    input logic [31:0] x,
    input logic        neg
  );
    return neg ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Accumulator is {partial, operand bits} in both modes.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  muldiv_cls_t       cls,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;

  // Compute both candidate steps, pick by op class
  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]}
         + (acc[0] ? {1'b0, operand} : '0);
    diff = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
    acc_next = {sum, acc[XLEN-1:1]};
    if (cls == CLS_DIV) begin
      if (!diff[XLEN])
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc_next = {acc[2*XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Mult/div sequencer, HI/LO owner and pipeline stall source.
// MULDIV_FAST_MULT_EN selects a single-cycle multiply path.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            mf_req,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  muldiv_state_t     state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_next;
  logic [XLEN-1:0]   operand;
  muldiv_cls_t       cls;
  logic              neg_q, neg_r, div0;

  logic              accept;
  logic              sgn;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   q_fix, r_fix;
  logic [XLEN-1:0]   hi_fix, lo_fix;

  assign busy   = (state != IDLE);
  assign stall  = busy & (start | mf_req);
  assign accept = (state == IDLE) & start & ~flush
                & is_muldiv(op);
  assign sgn    = is_signed_op(op);
  assign a_mag  = mag(op1, sgn & op1[XLEN-1]);
  assign b_mag  = mag(op2, sgn & op2[XLEN-1]);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc      (acc),
    .operand  (operand),
    .cls      (cls),
    .acc_next (acc_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; flush always wins
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef MULDIV_FAST_MULT_EN
          state_nx = (cls_of(op) == CLS_MUL) ? FIX : CALC;
`else
          state_nx = CALC;
`endif
        end
      end
      CALC: begin
        if (flush)         state_nx = IDLE;
        else if (cnt == 0) state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sign fixup of the raw accumulator into HI/LO values
  always_comb begin
    prod   = neg_q ? ('0 - acc) : acc;
    q_fix  = neg_q ? ('0 - acc[XLEN-1:0]) : acc[XLEN-1:0];
    r_fix  = neg_r ? ('0 - acc[2*XLEN-1:XLEN])
                   : acc[2*XLEN-1:XLEN];
    if (div0) q_fix = '1;
    hi_fix = prod[2*XLEN-1:XLEN];
    lo_fix = prod[XLEN-1:0];
    if (cls == CLS_DIV) begin
      hi_fix = r_fix;
      lo_fix = q_fix;
    end
  end

  // Datapath, counter and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      cls     <= CLS_MUL;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            if (op == MTHI) hi <= op1;
            if (op == MTLO) lo <= op1;
          end
          if (accept) begin
            cls   <= cls_of(op);
            neg_q <= sgn & (op1[XLEN-1] ^ op2[XLEN-1]);
            neg_r <= sgn & op1[XLEN-1];
            div0  <= (cls_of(op) == CLS_DIV) && (op2 == '0);
            cnt   <= CNT_W'(ITER_LAST);
            if (cls_of(op) == CLS_DIV) begin
              acc     <= {{XLEN{1'b0}}, a_mag};
              operand <= b_mag;
            end else begin
`ifdef MULDIV_FAST_MULT_EN
              acc     <= (2*XLEN)'(a_mag) * (2*XLEN)'(b_mag);
`else
              acc     <= {{XLEN{1'b0}}, b_mag};
`endif
              operand <= a_mag;
            end
          end
        end
        CALC: begin
          if (!flush) begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (!flush) begin
            hi   <= hi_fix;
            lo   <= lo_fix;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
// Expected values are hand-computed constants.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  muldiv_op_t  op = MULTU;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        mf_req = 1'b0;
  logic        flush = 1'b0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .op1    (op1),
    .op2    (op2),
    .mf_req (mf_req),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic issue(input muldiv_op_t o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      n = i;
      if (done) break;
    end
    if (!done) n = 999;
  endtask

  task automatic run_op(input string nm,
                        input muldiv_op_t o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int lat,
                        input logic [31:0] ehi,
                        input logic [31:0] elo);
    int n;
    issue(o, a, b);
    wait_done(n);
    n_cmp++;
    if (n !== lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d want %0d", nm, n, lat);
    end
    n_cmp++;
    if (hi !== ehi || lo !== elo) begin
      n_bad++;
      $display("FAIL %s hi/lo: got %h/%h want %h/%h",
               nm, hi, lo, ehi, elo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({hi, lo} !== 64'd0 || busy !== 1'b0 ||
        done !== 1'b0 || stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b",
               hi, lo, busy, done, stall);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_mult();
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg", MULT, 32'hFFFF_FFFE, 32'd3,
           MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("mult_6x7", MULT, 32'd6, 32'd7,
           MUL_LAT, 32'd0, 32'd42);
  endtask

  task automatic test_div();
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2,
           DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE,
           DIV_LAT, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_7_0", DIVU, 32'd7, 32'd0,
           DIV_LAT, 32'd7, 32'hFFFF_FFFF);
    run_op("div_m5_0", DIV, 32'hFFFF_FFFB, 32'd0,
           DIV_LAT, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           DIV_LAT, 32'd0, 32'h8000_0000);
  endtask

  task automatic test_stall();
    int n;
    logic bad_st, bad_hl;
    bad_st = 1'b0; bad_hl = 1'b0;
    issue(MTHI, 32'h0000_AAAA, 32'd0);
    issue(MTLO, 32'h0000_BBBB, 32'd0);
    issue(DIVU, 32'd100, 32'd7);
    n = 999;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
      if (i == 10) begin
        start = 1'b1; op = MULTU;
        op1 = 32'd9; op2 = 32'd9; mf_req = 1'b1;
        #1;
      end
      if (i >= 10 && stall !== 1'b1) bad_st = 1'b1;
      if (hi !== 32'h0000_AAAA || lo !== 32'h0000_BBBB)
        bad_hl = 1'b1;
    end
    start = 1'b0; mf_req = 1'b0;
    n_cmp++;
    if (bad_st) begin
      n_bad++;
      $display("FAIL stall_hold: got 0 want 1 while busy");
    end
    n_cmp++;
    if (bad_hl) begin
      n_bad++;
      $display("FAIL stall_hilo: got early write want %h/%h",
               32'hAAAA, 32'hBBBB);
    end
    n_cmp++;
    if (n !== 33 || hi !== 32'd2 || lo !== 32'd14) begin
      n_bad++;
      $display("FAIL stall_div: got n=%0d %h/%h want 33 2/e",
               n, hi, lo);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_ignored: got busy=%b done=%b want 0/0",
               busy, done);
    end
  endtask

  task automatic test_mt_flush();
    logic seen;
    seen = 1'b0;
    issue(MTHI, 32'h0000_1234, 32'd0);
    n_cmp++;
    if (hi !== 32'h0000_1234) begin
      n_bad++;
      $display("FAIL mthi: got %h want 00001234", hi);
    end
    issue(MTLO, 32'h0000_0077, 32'd0);
    n_cmp++;
    if (lo !== 32'h0000_0077 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mtlo: got %h busy=%b want 00000077 0",
               lo, busy);
    end
    issue(DIV, 32'd50, 32'd5);
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        hi !== 32'h0000_1234 || lo !== 32'h0000_0077) begin
      n_bad++;
      $display("FAIL flush: got busy=%b done=%b %h/%h want 0 0 1234/77",
               busy, done, hi, lo);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_nodone: got pulse want none");
    end
    @(negedge clk);
    start = 1'b1; op = MTHI; op1 = 32'hDEAD; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    n_cmp++;
    if (hi !== 32'h0000_1234) begin
      n_bad++;
      $display("FAIL flush_start: got %h want 00001234", hi);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_divu", DIVU, 32'd100, 32'd7,
           DIV_LAT, 32'd2, 32'd14);
    run_op("b2b_multu", MULTU, 32'd3, 32'd5,
           MUL_LAT, 32'd0, 32'd15);
  endtask

  task automatic test_reset_mid();
    issue(MULTU, 32'd11, 32'd13);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got busy=%b done=%b %h/%h want 0 0 0/0",
               busy, done, hi, lo);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_mt_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
